cai_comp_ring_mux: RTL and testbench

CAI_COMP_RING_MUX -- requirements
Module: cai_comp_ring_mux

---
 rtl/cai_comp_ring_mux.sv | 133 +++++++++++++
 tb/tb_cai_comp_ring_mux.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cai_comp_ring_mux.sv
// Completion ring multiplexer: arbitrates engine completion channels round-robin
// into 16-byte ring records and coalesces completion doorbells.
module cai_comp_ring_mux #(
   parameter int NCH            = 4,
   parameter int COMP_REC_BYTES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [63:0]       comp_base,
   input  logic [31:0]       comp_ring_mask,
   input  logic [31:0]       comp_cons_idx,
   input  logic [7:0]        coal_count,
   input  logic [NCH-1:0]    ch_valid,
   output logic [NCH-1:0]    ch_ready,
   input  logic [NCH*32-1:0] ch_tag,
   input  logic [NCH*16-1:0] ch_status,
   input  logic [NCH*16-1:0] ch_ext_status,
   input  logic [NCH*32-1:0] ch_bytes,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [63:0]       wr_addr,
   output logic [127:0]      wr_data,
   output logic [31:0]       comp_prod_idx,
   output logic              comp_doorbell,
   output logic              ring_full
);

   localparam int PW        = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int REC_SHIFT = $clog2(COMP_REC_BYTES);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t        state;
   logic [PW-1:0] rr_last;
   logic [PW-1:0] pick;
   logic          found;
   logic          grant;
   logic          any_valid;
   logic [7:0]    pend;
   logic [7:0]    coal_eff;
   logic [31:0]   in_flight;
   logic [31:0]   sel_tag;
   logic [15:0]   sel_status;
   logic [15:0]   sel_ext;
   logic [31:0]   sel_bytes;
   logic [63:0]   rec_addr;

   // Modular difference keeps the full test correct across 32-bit index wrap.
   assign in_flight = comp_prod_idx - comp_cons_idx;
   assign ring_full = in_flight > comp_ring_mask;
   assign any_valid = |ch_valid;
   assign coal_eff  = (coal_count == 8'd0) ? 8'd1 : coal_count;
   assign grant     = (state == IDLE) && enable && !ring_full && found;
   assign rec_addr  = comp_base + ({32'b0, comp_prod_idx & comp_ring_mask} << REC_SHIFT);

   // Search starts one past the last granted channel so every requester gets a turn.
   always_comb begin
      logic [PW-1:0] c;
      c     = rr_last;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         c = (c == PW'(NCH - 1)) ? '0 : c + 1'b1;
         if (!found && ch_valid[c]) begin
            found = 1'b1;
            pick  = c;
         end
      end
   end

   always_comb begin
      sel_tag    = '0;
      sel_status = '0;
      sel_ext    = '0;
      sel_bytes  = '0;
      ch_ready   = '0;
      for (int k = 0; k < NCH; k++) begin
         if (PW'(k) == pick) begin
            sel_tag    = ch_tag[k*32 +: 32];
            sel_status = ch_status[k*16 +: 16];
            sel_ext    = ch_ext_status[k*16 +: 16];
            sel_bytes  = ch_bytes[k*32 +: 32];
            ch_ready[k] = grant;
         end
      end
   end

   // Doorbell fires on reaching the coalescing threshold or when traffic dries up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         comp_prod_idx <= '0;
         pend          <= '0;
         rr_last       <= PW'(NCH - 1);
         wr_valid      <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         comp_doorbell <= 1'b0;
      end else begin
         comp_doorbell <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  rr_last  <= pick;
                  wr_valid <= 1'b1;
                  wr_addr  <= rec_addr;
                  wr_data  <= {32'b0, sel_bytes, sel_ext, sel_status, sel_tag};
                  state    <= WRITE;
               end else if (pend != 8'd0 && !any_valid) begin
                  comp_doorbell <= 1'b1;
                  pend          <= '0;
               end
            end
            WRITE: begin
               if (wr_ready) begin
                  wr_valid      <= 1'b0;
                  comp_prod_idx <= comp_prod_idx + 32'd1;
                  state         <= IDLE;
                  if (({1'b0, pend} + 9'd1 >= {1'b0, coal_eff}) || !any_valid) begin
                     comp_doorbell <= 1'b1;
                     pend          <= '0;
                  end else begin
                     pend <= pend + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cai_comp_ring_mux.sv
// Self-checking bench for cai_comp_ring_mux: directed scenarios plus randomized
// traffic compared against a transaction-level ring/doorbell model.
module tb_cai_comp_ring_mux;

   localparam int NCH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [63:0]       comp_base;
   logic [31:0]       comp_ring_mask;
   logic [31:0]       comp_cons_idx;
   logic [7:0]        coal_count;
   logic [NCH-1:0]    ch_valid;
   logic [NCH-1:0]    ch_ready;
   logic [NCH*32-1:0] ch_tag;
   logic [NCH*16-1:0] ch_status;
   logic [NCH*16-1:0] ch_ext_status;
   logic [NCH*32-1:0] ch_bytes;
   logic              wr_valid;
   logic              wr_ready;
   logic [63:0]       wr_addr;
   logic [127:0]      wr_data;
   logic [31:0]       comp_prod_idx;
   logic              comp_doorbell;
   logic              ring_full;

   int          vectors     = 0;
   int          miscompares = 0;
   int unsigned m_prod;
   int          m_last;
   int unsigned m_pend;
   bit          m_busy;
   bit          m_db;
   logic [63:0] m_addr;
   logic [127:0] m_data;
   int          db_count;
   int          grants[$];

   always #5 clk = ~clk;

   cai_comp_ring_mux #(.NCH(NCH), .COMP_REC_BYTES(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .comp_base(comp_base),
      .comp_ring_mask(comp_ring_mask), .comp_cons_idx(comp_cons_idx),
      .coal_count(coal_count), .ch_valid(ch_valid), .ch_ready(ch_ready),
      .ch_tag(ch_tag), .ch_status(ch_status), .ch_ext_status(ch_ext_status),
      .ch_bytes(ch_bytes), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .comp_prod_idx(comp_prod_idx),
      .comp_doorbell(comp_doorbell), .ring_full(ring_full)
   );

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int c, input logic [31:0] tag, input logic [15:0] st,
                         input logic [15:0] ext, input logic [31:0] nbytes);
      ch_tag[c*32 +: 32]        = tag;
      ch_status[c*16 +: 16]     = st;
      ch_ext_status[c*16 +: 16] = ext;
      ch_bytes[c*32 +: 32]      = nbytes;
   endtask

   function automatic int pick_next();
      for (int i = 1; i <= NCH; i++) begin
         if (ch_valid[(m_last + i) % NCH]) return (m_last + i) % NCH;
      end
      return -1;
   endfunction

   // Called at a falling edge with inputs already driven; checks, then advances one cycle.
   task automatic run_cycle();
      bit             m_full;
      bit             next_db;
      int             p;
      int unsigned    thresh;
      logic [NCH-1:0] exp_ready;
      #1;
      m_full    = (m_prod - comp_cons_idx) > comp_ring_mask;
      p         = pick_next();
      exp_ready = '0;
      if (!m_busy && enable && !m_full && p >= 0) exp_ready[p] = 1'b1;
      check_output("ring_full", ring_full, m_full);
      check_output("prod_idx", comp_prod_idx, m_prod);
      check_output("doorbell", comp_doorbell, m_db);
      check_output("wr_valid", wr_valid, m_busy);
      check_output("ch_ready", ch_ready, exp_ready);
      if (m_busy) begin
         check_output("wr_addr", wr_addr, m_addr);
         check_output("wr_data", wr_data, m_data);
      end
      if (comp_doorbell) db_count++;
      thresh  = (coal_count == 0) ? 1 : coal_count;
      next_db = 1'b0;
      if (m_busy) begin
         if (wr_ready) begin
            m_prod++;
            m_busy = 1'b0;
            if (m_pend + 1 >= thresh || ch_valid == '0) begin
               next_db = 1'b1;
               m_pend  = 0;
            end else begin
               m_pend++;
            end
         end
      end else if (exp_ready != '0) begin
         m_busy = 1'b1;
         m_last = p;
         grants.push_back(p);
         m_addr = comp_base + 64'(m_prod & comp_ring_mask) * 64'd16;
         m_data = {32'h0, ch_bytes[p*32 +: 32], ch_ext_status[p*16 +: 16],
                   ch_status[p*16 +: 16], ch_tag[p*32 +: 32]};
      end else if (m_pend > 0 && ch_valid == '0) begin
         next_db = 1'b1;
         m_pend  = 0;
      end
      @(posedge clk);
      m_db = next_db;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      ch_valid = '0;
      rst      = 1'b1;
      m_prod   = 0;
      m_last   = NCH - 1;
      m_pend   = 0;
      m_busy   = 1'b0;
      m_db     = 1'b0;
      #1;
      check_output("rst_wr_valid", wr_valid, 1'b0);
      check_output("rst_prod", comp_prod_idx, 32'd0);
      check_output("rst_doorbell", comp_doorbell, 1'b0);
      check_output("rst_wr_addr", wr_addr, 64'd0);
      check_output("rst_wr_data", wr_data, 128'd0);
      check_output("rst_ch_ready", ch_ready, '0);
      @(negedge clk);
      rst           = 1'b0;
      comp_cons_idx = '0;
   endtask

   initial begin
      enable         = 1'b0;
      wr_ready       = 1'b1;
      comp_base      = 64'h500;
      comp_ring_mask = 32'd7;
      comp_cons_idx  = '0;
      coal_count     = 8'd1;
      ch_tag         = '0;
      ch_status      = '0;
      ch_ext_status  = '0;
      ch_bytes       = '0;
      apply_reset();

      // Single record on channel 0.
      enable   = 1'b1;
      db_count = 0;
      set_ch(0, 32'hAABBCCDD, 16'h0, 16'h0, 32'd4);
      ch_valid = 4'b0001;
      run_cycle();
      ch_valid = '0;
      check_output("single_addr", wr_addr, 64'h500);
      check_output("single_tag", wr_data[31:0], 32'hAABBCCDD);
      check_output("single_bytes", wr_data[95:64], 32'd4);
      repeat (3) run_cycle();
      check_output("single_prod", comp_prod_idx, 32'd1);
      check_output("single_db_count", db_count, 1);

      // Round-robin fairness with all channels requesting.
      apply_reset();
      for (int c = 0; c < NCH; c++) set_ch(c, 32'h100 + c, 16'(c), 16'h1F, 32'(c * 8));
      grants.delete();
      ch_valid = 4'b1111;
      repeat (10) run_cycle();
      ch_valid = '0;
      check_output("rr_grant0", grants[0], 0);
      check_output("rr_grant1", grants[1], 1);
      check_output("rr_grant2", grants[2], 2);
      check_output("rr_grant3", grants[3], 3);
      check_output("rr_grant4", grants[4], 0);
      repeat (2) run_cycle();

      // Ring wrap and full: eight entries fill, the ninth waits for the consumer.
      apply_reset();
      ch_valid = 4'b0010;
      repeat (20) run_cycle();
      check_output("full_prod", comp_prod_idx, 32'd8);
      check_output("full_flag", ring_full, 1'b1);
      check_output("full_no_ready", ch_ready, '0);
      comp_cons_idx = 32'd1;
      run_cycle();
      check_output("wrap_addr", wr_addr, 64'h500);
      repeat (2) run_cycle();
      check_output("wrap_prod", comp_prod_idx, 32'd9);
      ch_valid = '0;
      comp_cons_idx = 32'd9;
      repeat (2) run_cycle();

      // Coalescing: threshold 4, six back-to-back records on channel 2.
      apply_reset();
      coal_count = 8'd4;
      db_count   = 0;
      ch_valid   = 4'b0100;
      repeat (11) run_cycle();
      ch_valid = '0;
      repeat (4) run_cycle();
      check_output("coal_db_count", db_count, 2);
      check_output("coal_prod", comp_prod_idx, 32'd6);

      // Backpressure holds the record steady.
      apply_reset();
      coal_count = 8'd1;
      wr_ready   = 1'b0;
      set_ch(3, 32'hDEAD0003, 16'h33, 16'h5, 32'd64);
      ch_valid = 4'b1000;
      repeat (11) run_cycle();
      check_output("bp_prod", comp_prod_idx, 32'd0);
      check_output("bp_wr_valid", wr_valid, 1'b1);
      wr_ready = 1'b1;
      ch_valid = '0;
      repeat (3) run_cycle();

      // Reset while a write is outstanding.
      wr_ready = 1'b0;
      ch_valid = 4'b0001;
      run_cycle();
      db_count = 0;
      #2;
      apply_reset();
      wr_ready = 1'b1;
      repeat (3) run_cycle();
      check_output("rst_mid_db", db_count, 0);

      // Randomized segments; configuration only changes while disabled and idle.
      for (int seg = 0; seg < 8; seg++) begin
         enable   = 1'b0;
         ch_valid = '0;
         wr_ready = 1'b1;
         repeat (3) run_cycle();
         comp_base      = {$urandom, $urandom};
         comp_ring_mask = (32'd1 << $urandom_range(0, 4)) - 32'd1;
         coal_count     = 8'($urandom_range(0, 5));
         comp_cons_idx  = m_prod;
         enable         = 1'b1;
         for (int n = 0; n < 150; n++) begin
            enable   = ($urandom_range(0, 9) != 0);
            ch_valid = 4'($urandom);
            wr_ready = ($urandom_range(0, 9) < 7);
            for (int c = 0; c < NCH; c++)
               set_ch(c, $urandom, 16'($urandom), 16'($urandom), $urandom);
            if (comp_cons_idx != m_prod && $urandom_range(0, 2) == 0)
               comp_cons_idx = comp_cons_idx + 32'd1;
            run_cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
